ofdm_sync_controller: RTL

Sequencing controller for the Schmidl-Cox synchronisation datapath (metric calculator plus detector) in the OFDM receive chain. It owns the threshold and packet-length configuration, shadowing software writes so they apply only between frames. It arms and disarms detection and counts the payload beats of each captured frame. It also enforces a hold-off gap before re-arming and reports frame, overrun and timeout statistics to software over a CtrlPort-style register interface.

---
 rtl/ofdm_sync_ctrl_pkg.sv | 31 +++
 rtl/ofdm_sync_ctrl_regs.sv | 126 ++++++++++++
 rtl/ofdm_sync_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ofdm_sync_ctrl_pkg.sv
// Shared types and constants for the Schmidl-Cox sync controller:
// FSM state encoding, register map, CTRL bit positions and reset defaults.
package ofdm_sync_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  localparam logic [2:0] ADDR_THRESHOLD = 3'd0;
  localparam logic [2:0] ADDR_PKT_LEN   = 3'd1;
  localparam logic [2:0] ADDR_CTRL      = 3'd2;
  localparam logic [2:0] ADDR_HOLDOFF   = 3'd3;
  localparam logic [2:0] ADDR_STATUS    = 3'd4;

  localparam int CTRL_ENABLE_BIT    = 0;
  localparam int CTRL_ONESHOT_BIT   = 1;
  localparam int CTRL_ABORT_BIT     = 2;
  localparam int STATUS_TIMEOUT_BIT = 3;

  localparam logic [31:0] THRESHOLD_DEFAULT = 32'h0200_0000;
  localparam logic [31:0] PKT_LEN_DEFAULT   = 32'd2304;

  // A zero packet length would never complete a frame, so it behaves as one beat
  function automatic logic [31:0] effectiveLen(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/ofdm_sync_ctrl_regs.sv
// Register file for the sync controller: pending THRESHOLD/PKT_LEN copies,
// the active copies driven to the detector, CTRL/HOLDOFF storage, the
// timeout sticky bit and the registered cfg_ack/cfg_rdata response.
module ofdm_sync_ctrl_regs
  import ofdm_sync_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  output logic        cfg_ack,
  output logic [31:0] cfg_rdata,
  input  logic        i_shadowEn,
  input  logic        i_enClr,
  input  logic        i_timeoutSet,
  input  logic [1:0]  i_state,
  input  logic [7:0]  i_overrun,
  input  logic [15:0] i_frames,
  output logic [31:0] o_detThreshold,
  output logic [31:0] o_detPacketLength,
  output logic        o_enable,
  output logic        o_oneShot,
  output logic        o_abort,
  output logic [31:0] o_holdoff
);

  logic [31:0] r_thrPend;
  logic [31:0] r_lenPend;
  logic [31:0] r_detThr;
  logic [31:0] r_detLen;
  logic        r_enable;
  logic        r_oneShot;
  logic [31:0] r_holdoff;
  logic        r_timeout;
  logic        r_ack;
  logic [31:0] r_rdata;
  logic        w_wrThr;
  logic        w_wrLen;
  logic        w_wrCtrl;
  logic        w_wrHold;
  logic        w_wrStatus;
  logic [31:0] w_thrNext;
  logic [31:0] w_lenNext;
  logic [31:0] w_rdMux;

  assign w_wrThr    = cfg_wr && (cfg_addr == ADDR_THRESHOLD);
  assign w_wrLen    = cfg_wr && (cfg_addr == ADDR_PKT_LEN);
  assign w_wrCtrl   = cfg_wr && (cfg_addr == ADDR_CTRL);
  assign w_wrHold   = cfg_wr && (cfg_addr == ADDR_HOLDOFF);
  assign w_wrStatus = cfg_wr && (cfg_addr == ADDR_STATUS);

  // Forward a same-cycle write so the active copy follows one clock after the write
  assign w_thrNext = w_wrThr ? cfg_data : r_thrPend;
  assign w_lenNext = w_wrLen ? cfg_data : r_lenPend;

  assign o_abort = w_wrCtrl && cfg_data[CTRL_ABORT_BIT];

  // Software-visible register storage; FSM-driven clears/sets win over writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_thrPend <= THRESHOLD_DEFAULT;
      r_lenPend <= PKT_LEN_DEFAULT;
      r_enable  <= 1'b0;
      r_oneShot <= 1'b0;
      r_holdoff <= 32'd0;
      r_timeout <= 1'b0;
    end else begin
      if (w_wrThr) r_thrPend <= cfg_data;
      if (w_wrLen) r_lenPend <= cfg_data;
      if (w_wrCtrl) begin
        r_enable  <= cfg_data[CTRL_ENABLE_BIT];
        r_oneShot <= cfg_data[CTRL_ONESHOT_BIT];
      end
      if (i_enClr) r_enable <= 1'b0;
      if (w_wrHold) r_holdoff <= cfg_data;
      if (w_wrStatus && cfg_data[STATUS_TIMEOUT_BIT]) r_timeout <= 1'b0;
      if (i_timeoutSet) r_timeout <= 1'b1;
    end
  end

  // Active detector configuration only tracks the pending copy between frames
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_detThr <= THRESHOLD_DEFAULT;
      r_detLen <= PKT_LEN_DEFAULT;
    end else if (i_shadowEn) begin
      r_detThr <= w_thrNext;
      r_detLen <= effectiveLen(w_lenNext);
    end
  end

  // Read mux built from pre-write values, so a simultaneous read sees old data
  always_comb begin
    w_rdMux = 32'd0;
    case (cfg_addr)
      ADDR_THRESHOLD: w_rdMux = r_thrPend;
      ADDR_PKT_LEN:   w_rdMux = r_lenPend;
      ADDR_CTRL:      w_rdMux = {30'd0, r_oneShot, r_enable};
      ADDR_HOLDOFF:   w_rdMux = r_holdoff;
      ADDR_STATUS:    w_rdMux = {i_frames, i_overrun, 4'd0, r_timeout, 1'b0, i_state};
      default:        w_rdMux = 32'd0;
    endcase
  end

  // One-cycle acknowledge with registered read data for every access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ack   <= cfg_wr || cfg_rd;
      r_rdata <= cfg_rd ? w_rdMux : 32'd0;
    end
  end

  assign cfg_ack           = r_ack;
  assign cfg_rdata         = r_rdata;
  assign o_detThreshold    = r_detThr;
  assign o_detPacketLength = r_detLen;
  assign o_enable          = r_enable;
  assign o_oneShot         = r_oneShot;
  assign o_holdoff         = r_holdoff;

endmodule

// File: rtl/ofdm_sync_controller.sv
// Sequencing controller for the Schmidl-Cox metric/detector pair: arms
// detection, counts payload beats per frame, enforces a re-arm hold-off and
// keeps frame/overrun statistics. Define SC_CTRL_TIMEOUT_EN to add a capture
// watchdog that abandons a frame after TIMEOUT_CYCLES beat-free clocks.
module ofdm_sync_controller
  import ofdm_sync_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  output logic        cfg_ack,
  output logic [31:0] cfg_rdata,
  output logic [31:0] det_threshold,
  output logic [31:0] det_packet_length,
  output logic        det_clear,
  input  logic        det_found,
  input  logic        beat_valid,
  output logic        busy,
  output logic        irq
);

  state_t           r_state;
  logic [CNT_W-1:0] r_beatCnt;
  logic [CNT_W-1:0] r_frameCnt;
  logic [7:0]       r_overrun;
  logic [31:0]      r_holdCnt;
  logic             r_detClear;
  logic             r_irq;
  logic             r_busy;
  logic             w_enable;
  logic             w_oneShot;
  logic             w_abort;
  logic [31:0]      w_holdoff;
  logic             w_shadowEn;
  logic             w_lastBeat;
  logic             w_enClr;
  logic             w_timeout;
  logic             w_timeoutSet;

  assign w_shadowEn   = (r_state == ST_IDLE) || (r_state == ST_ARMED);
  assign w_lastBeat   = (r_state == ST_CAPTURE) && beat_valid &&
                        ((32'(r_beatCnt) + 32'd1) >= det_packet_length);
  assign w_enClr      = w_lastBeat && w_oneShot && !w_abort;
  assign w_timeoutSet = w_timeout && !w_abort;

  ofdm_sync_ctrl_regs u_regs (
    .clk               (clk),
    .reset_n           (reset_n),
    .cfg_wr            (cfg_wr),
    .cfg_rd            (cfg_rd),
    .cfg_addr          (cfg_addr),
    .cfg_data          (cfg_data),
    .cfg_ack           (cfg_ack),
    .cfg_rdata         (cfg_rdata),
    .i_shadowEn        (w_shadowEn),
    .i_enClr           (w_enClr),
    .i_timeoutSet      (w_timeoutSet),
    .i_state           (r_state),
    .i_overrun         (r_overrun),
    .i_frames          (16'(r_frameCnt)),
    .o_detThreshold    (det_threshold),
    .o_detPacketLength (det_packet_length),
    .o_enable          (w_enable),
    .o_oneShot         (w_oneShot),
    .o_abort           (w_abort),
    .o_holdoff         (w_holdoff)
  );

`ifdef SC_CTRL_TIMEOUT_EN
  logic [31:0] r_idleCnt;

  // Count consecutive beat-free clocks while a frame is being captured
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idleCnt <= 32'd0;
    end else if ((r_state != ST_CAPTURE) || beat_valid) begin
      r_idleCnt <= 32'd0;
    end else begin
      r_idleCnt <= r_idleCnt + 32'd1;
    end
  end

  assign w_timeout = (r_state == ST_CAPTURE) && !beat_valid &&
                     (r_idleCnt == 32'(TIMEOUT_CYCLES - 1));
`else
  logic w_unusedTimeout;
  assign w_unusedTimeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout       = 1'b0;
`endif

  // Main sequencer: abort first, then per-state arming, capture and hold-off
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_beatCnt  <= '0;
      r_frameCnt <= '0;
      r_overrun  <= 8'd0;
      r_holdCnt  <= 32'd0;
      r_detClear <= 1'b0;
      r_irq      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_detClear <= 1'b0;
      r_irq      <= 1'b0;
      if (w_abort) begin
        r_state    <= ST_IDLE;
        r_detClear <= 1'b1;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_enable) begin
              r_state    <= ST_ARMED;
              r_detClear <= 1'b1;
            end
          end
          ST_ARMED: begin
            if (det_found) begin
              r_state   <= ST_CAPTURE;
              r_beatCnt <= '0;
              r_busy    <= 1'b1;
            end else if (!w_enable) begin
              r_state <= ST_IDLE;
            end
          end
          ST_CAPTURE: begin
            if (det_found && (r_overrun != 8'hFF)) r_overrun <= r_overrun + 8'd1;
            if (w_timeout) begin
              r_state    <= ST_ARMED;
              r_detClear <= 1'b1;
              r_busy     <= 1'b0;
            end else if (beat_valid) begin
              r_beatCnt <= r_beatCnt + 1'b1;
              if (w_lastBeat) begin
                r_frameCnt <= r_frameCnt + 1'b1;
                r_irq      <= 1'b1;
                if (w_holdoff != 32'd0) begin
                  r_state   <= ST_HOLDOFF;
                  r_holdCnt <= w_holdoff;
                end else if (w_oneShot || !w_enable) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                end else begin
                  r_state    <= ST_ARMED;
                  r_detClear <= 1'b1;
                  r_busy     <= 1'b0;
                end
              end
            end
          end
          ST_HOLDOFF: begin
            if (r_holdCnt <= 32'd1) begin
              r_state    <= w_enable ? ST_ARMED : ST_IDLE;
              r_detClear <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_holdCnt <= r_holdCnt - 32'd1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign det_clear = r_detClear;
  assign irq       = r_irq;
  assign busy      = r_busy;

endmodule
